// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding, default widths,
// HLT opcode and FIFO entry sizing ({instr, pc}).
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_WAIT   = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_e;

   localparam int         DEF_ADDR_W      = 16;
   localparam int         DEF_INSTR_W     = 16;
   localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

   function automatic int entry_width(input int instr_w, input int addr_w);
      return instr_w + addr_w;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO with flush; head is shown combinationally and forced to zero when empty.
// Zero-latency head; push/pop together at any count, flush beats both, caller never pushes when full.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_dat_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   head_vld_o,
   output logic [WIDTH-1:0]       head_dat_o
);

   localparam int             PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL  = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && !flush_i && (count_q != '0);
   assign do_push = push_i && !flush_i && ((count_q != FULL) || do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is read while count is zero.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign count_o    = count_q;
   assign head_vld_o = (count_q != '0);
   assign head_dat_o = head_vld_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, single-outstanding imem requests, {instr,pc} FIFO to decode.
// Registered req; 1-cycle imem gives req->instr_valid of 2 cycles; stops issuing while FIFO+in-flight would overflow.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                INSTR_W  = DEF_INSTR_W,
   parameter int                DEPTH    = 4,
   parameter int                PC_STEP  = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]        HALT_OP  = HALT_OP_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_rvalid,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               halted
);

   localparam int ENTRY_W = entry_width(INSTR_W, ADDR_W);
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              req_q, req_d;
   logic              out_q, out_d;
   logic              halted_q, halted_d;

   logic               push, pop, has_space, rsp_halt;
   logic [CNT_W-1:0]   fifo_cnt;
   logic [ENTRY_W-1:0] head_dat;

   assign has_space = (int'(fifo_cnt) + int'(out_q)) < DEPTH;
   assign rsp_halt  = (mem_rdata[INSTR_W-1 -: 4] == HALT_OP);
   assign pop       = instr_valid && instr_ready && !redirect_valid;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      req_d    = 1'b0;
      out_d    = out_q;
      halted_d = halted_q;
      push     = 1'b0;
      if (redirect_valid) begin
         pc_d     = redirect_pc;
         halted_d = 1'b0;
         case (state_q)
            // A response landing with the redirect retires the in-flight request.
            ST_WAIT, ST_DRAIN: begin
               if (mem_rvalid) begin
                  state_d = ST_FETCH;
                  out_d   = 1'b0;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
            default: state_d = ST_FETCH;
         endcase
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (has_space) begin
                  req_d   = 1'b1;
                  addr_d  = pc_q;
                  out_d   = 1'b1;
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  push  = 1'b1;
                  out_d = 1'b0;
                  if (rsp_halt) begin
                     halted_d = 1'b1;
                     state_d  = ST_HALTED;
                  end else begin
                     pc_d    = pc_q + ADDR_W'(PC_STEP);
                     state_d = ST_FETCH;
                  end
               end
            end
            ST_DRAIN: begin
               if (mem_rvalid) begin
                  out_d   = 1'b0;
                  state_d = ST_FETCH;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_FETCH;
         pc_q     <= RESET_PC;
         addr_q   <= RESET_PC;
         req_q    <= 1'b0;
         out_q    <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         req_q    <= req_d;
         out_q    <= out_d;
         halted_q <= halted_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push),
      .push_dat_i ({mem_rdata, pc_q}),
      .pop_i      (pop),
      .flush_i    (redirect_valid),
      .count_o    (fifo_cnt),
      .head_vld_o (instr_valid),
      .head_dat_o (head_dat)
   );

   assign mem_req  = req_q;
   assign mem_addr = addr_q;
   assign halted   = halted_q;
   assign instr    = head_dat[ENTRY_W-1 -: INSTR_W];
   assign instr_pc = head_dat[ADDR_W-1:0];

endmodule
